// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port: round-robin
// between ALU (A) and load (B) writers, plus a pending-write scoreboard for RAW hazard checks.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic                  ValidA,
    input  logic [ADDR_WIDTH-1:0] AddrA,
    input  logic [DATA_WIDTH-1:0] DataA,
    output logic                  ReadyA,
    input  logic                  ValidB,
    input  logic [ADDR_WIDTH-1:0] AddrB,
    input  logic [DATA_WIDTH-1:0] DataB,
    output logic                  ReadyB,
    input  logic                  ReserveEn,
    input  logic [ADDR_WIDTH-1:0] ReserveAddr,
    input  logic [ADDR_WIDTH-1:0] CheckAddr1,
    input  logic [ADDR_WIDTH-1:0] CheckAddr2,
    output logic                  Busy1,
    output logic                  Busy2,
    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  prioB;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] winAddr;
    logic [DATA_WIDTH-1:0] winData;
    logic [DEPTH-1:0]      pending;

    assign ReadyA  = ValidA & (~ValidB | ~prioB);
    assign ReadyB  = ValidB & (~ValidA | prioB);
    assign xfer    = ReadyA | ReadyB;
    assign winAddr = ReadyB ? AddrB : AddrA;
    assign winData = ReadyB ? DataB : DataA;

    // On contention the pointer moves to whoever lost this edge.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)
            prioB <= 1'b0;
        else if (ValidA && ValidB)
            prioB <= ReadyA;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= xfer && (winAddr != '0);
            if (xfer) begin
                WriteRegister <= winAddr;
                WriteData     <= winData;
            end
        end
    end

    // Reserve beats clear so a back-to-back producer keeps its register busy.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pending <= '0;
        end else begin
            pending[0] <= 1'b0;
            for (int i = 1; i < DEPTH; i++) begin
                if (ReserveEn && ReserveAddr == ADDR_WIDTH'(i))
                    pending[i] <= 1'b1;
                else if (RegWrite && WriteRegister == ADDR_WIDTH'(i))
                    pending[i] <= 1'b0;
            end
        end
    end

    assign Busy1 = pending[CheckAddr1];
    assign Busy2 = pending[CheckAddr2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of regfile_wb_arbiter against a cycle-level
// reference model of grants, priority, output register and scoreboard.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          Clk, nReset;
    logic          ValidA, ValidB, ReadyA, ReadyB;
    logic [AW-1:0] AddrA, AddrB, ReserveAddr, CheckAddr1, CheckAddr2, WriteRegister;
    logic [DW-1:0] DataA, DataB, WriteData;
    logic          ReserveEn, Busy1, Busy2, RegWrite;

    int checks = 0;
    int errors = 0;

    bit          mPrioA;
    bit          mPending [32];
    bit          mRegWrite;
    logic [4:0]  mWReg;
    logic [31:0] mWData;
    bit          obsRA, obsRB;
    logic [3:0]  seq;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk(Clk), .nReset(nReset),
        .ValidA(ValidA), .AddrA(AddrA), .DataA(DataA), .ReadyA(ReadyA),
        .ValidB(ValidB), .AddrB(AddrB), .DataB(DataB), .ReadyB(ReadyB),
        .ReserveEn(ReserveEn), .ReserveAddr(ReserveAddr),
        .CheckAddr1(CheckAddr1), .CheckAddr2(CheckAddr2),
        .Busy1(Busy1), .Busy2(Busy2),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPrioA    = 1'b1;
        foreach (mPending[i]) mPending[i] = 1'b0;
        mRegWrite = 1'b0;
        mWReg     = '0;
        mWData    = '0;
    endtask

    // Caller drives inputs just after a rising edge; this checks the
    // combinational outputs mid-cycle, advances the model, then checks registers.
    task automatic cycle();
        bit gA, gB;
        @(negedge Clk);
        gA = ValidA && (!ValidB || mPrioA);
        gB = ValidB && !gA;
        obsRA = ReadyA;
        obsRB = ReadyB;
        check("readyA", ReadyA, gA);
        check("readyB", ReadyB, gB);
        check("readyExclusive", ReadyA && ReadyB, 0);
        check("busy1", Busy1, mPending[CheckAddr1]);
        check("busy2", Busy2, mPending[CheckAddr2]);
        @(posedge Clk);
        if (mRegWrite) mPending[mWReg] = 1'b0;
        if (ReserveEn && ReserveAddr != 0) mPending[ReserveAddr] = 1'b1;
        if (ValidA && ValidB) mPrioA = gB;
        if (gA || gB) begin
            mWReg     = gA ? AddrA : AddrB;
            mWData    = gA ? DataA : DataB;
            mRegWrite = (mWReg != 0);
        end else begin
            mRegWrite = 1'b0;
        end
        #1;
        check("regWrite", RegWrite, mRegWrite);
        check("writeRegister", WriteRegister, mWReg);
        check("writeData", WriteData, mWData);
    endtask

    initial begin
        nReset = 1'b0;
        ValidA = 0; AddrA = '0; DataA = '0;
        ValidB = 0; AddrB = '0; DataB = '0;
        ReserveEn = 0; ReserveAddr = '0; CheckAddr1 = '0; CheckAddr2 = '0;
        obsRA = 0; obsRB = 0;
        modelReset();

        repeat (2) @(posedge Clk);
        #1;
        check("rstRegWrite", RegWrite, 0);
        check("rstWriteRegister", WriteRegister, 0);
        check("rstWriteData", WriteData, 0);
        nReset = 1'b1;
        cycle();
        cycle();

        // Single writer
        ValidA = 1; AddrA = 5; DataA = 32'hDEADBEEF;
        cycle();
        ValidA = 0;
        check("singleReady", obsRA, 1);
        check("singleRegWrite", RegWrite, 1);
        check("singleAddr", WriteRegister, 5);
        check("singleData", WriteData, 32'hDEADBEEF);
        cycle();
        check("singleRegWriteDrop", RegWrite, 0);

        // Contention: both held high four cycles
        ValidA = 1; AddrA = 1; DataA = 32'h11;
        ValidB = 1; AddrB = 2; DataB = 32'h22;
        seq = '0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            seq = {seq[2:0], obsRA};
            if (obsRA) begin AddrA = AW'(10 + k); DataA = 32'h100 + k; end
            else       begin AddrB = AW'(20 + k); DataB = 32'h200 + k; end
        end
        ValidA = 0; ValidB = 0;
        check("grantOrder", seq, 4'b1010);
        cycle();

        // Register zero write is accepted but dropped
        ValidB = 1; AddrB = 0; DataB = 32'h12345678;
        cycle();
        ValidB = 0;
        check("zeroReady", obsRB, 1);
        check("zeroRegWrite", RegWrite, 0);
        cycle();

        // Scoreboard lifecycle
        ReserveEn = 1; ReserveAddr = 7; CheckAddr1 = 7;
        cycle();
        ReserveEn = 0;
        check("sbSet", Busy1, 1);
        ValidA = 1; AddrA = 7; DataA = 32'h77;
        cycle();
        ValidA = 0;
        check("sbBusyDuringWrite", Busy1, 1);
        cycle();
        check("sbCleared", Busy1, 0);
        ReserveEn = 1; ReserveAddr = 0; CheckAddr2 = 0;
        cycle();
        ReserveEn = 0;
        check("sbZeroNeverBusy", Busy2, 0);

        // Reserve and clear of the same register on one edge
        ReserveEn = 1; ReserveAddr = 9; CheckAddr1 = 9;
        cycle();
        ReserveEn = 0;
        ValidA = 1; AddrA = 9; DataA = 32'h99;
        cycle();
        ValidA = 0;
        ReserveEn = 1; ReserveAddr = 9;
        cycle();
        ReserveEn = 0;
        check("sbReserveWins", Busy1, 1);
        cycle();
        check("sbReserveHeld", Busy1, 1);

        // Reset with a captured write outstanding
        ReserveEn = 1; ReserveAddr = 3; CheckAddr1 = 3;
        cycle();
        ReserveEn = 0;
        ValidA = 1; AddrA = 4; DataA = 32'hCAFE;
        cycle();
        ValidA = 0;
        #2 nReset = 1'b0;
        #1;
        check("midRstRegWrite", RegWrite, 0);
        check("midRstWriteRegister", WriteRegister, 0);
        check("midRstWriteData", WriteData, 0);
        check("midRstBusy1", Busy1, 0);
        check("midRstBusy2", Busy2, 0);
        modelReset();
        @(posedge Clk);
        #1 nReset = 1'b1;
        cycle();

        // Random traffic obeying the hold-until-ready rule
        obsRA = 0; obsRB = 0;
        for (int n = 0; n < 400; n++) begin
            if (!(ValidA && !obsRA)) begin
                ValidA = 1'($urandom_range(0, 1));
                AddrA  = AW'($urandom_range(0, 7));
                DataA  = $urandom;
            end
            if (!(ValidB && !obsRB)) begin
                ValidB = 1'($urandom_range(0, 1));
                AddrB  = AW'($urandom_range(0, 7));
                DataB  = $urandom;
            end
            ReserveEn   = ($urandom_range(0, 3) == 0);
            ReserveAddr = AW'($urandom_range(0, 7));
            CheckAddr1  = AW'($urandom_range(0, 7));
            CheckAddr2  = AW'($urandom_range(0, 7));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single synchronous write port between two writeback requesters: A (ALU result) and B (memory load).
- Also keeps a 32-entry pending-write scoreboard. The issue stage reserves a destination register; the block reports read-after-write hazards for two source addresses.
- Sits between the writeback sources and the register file's WriteData/WriteRegister/RegWrite inputs. All three outputs come straight from registers.

Parameters:
- DATA_WIDTH, 32, width of the write data.
- ADDR_WIDTH, 5, register address width; depth is 2^ADDR_WIDTH.

Ports:
- Clk  input  1  clock, positive edge.
- nReset  input  1  asynchronous, active-low reset.
- ValidA  input  1  requester A has a write pending.
- AddrA  input  ADDR_WIDTH  destination register for A.
- DataA  input  DATA_WIDTH  write data for A.
- ReadyA  output  1  A is accepted this cycle.
- ValidB, AddrB, DataB, ReadyB: same as the A ports, for requester B.
- ReserveEn  input  1  issue stage reserves a destination register.
- ReserveAddr  input  ADDR_WIDTH  register being reserved.
- CheckAddr1  input  ADDR_WIDTH  first source register to check.
- CheckAddr2  input  ADDR_WIDTH  second source register to check.
- Busy1  output  1  CheckAddr1 has a pending write.
- Busy2  output  1  CheckAddr2 has a pending write.
- RegWrite  output  1  write enable to the register file.
- WriteRegister  output  ADDR_WIDTH  write address to the register file.
- WriteData  output  DATA_WIDTH  write data to the register file.

Behaviour:
- Reset: one clock, asynchronous active-low. While nReset=0:
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - All pending bits 0.
  - Priority pointer = A.
- Reset mid-operation drops any write captured but not yet committed, and clears the scoreboard.
- Arbitration (combinational, same cycle):
  - Only one Valid high: that requester gets Ready=1.
  - Both Valid high: the requester named by the priority pointer gets Ready; the other gets Ready=0.
  - Neither Valid: both Ready=0.
  - Ready never asserts without its matching Valid.
- Handshake:
  - A transfer happens when Valid&&Ready at a rising edge.
  - A requester must hold Valid, Addr and Data stable until Ready is seen.
  - At most one transfer per cycle. Throughput is one write per cycle.
- Priority pointer:
  - Changes only at an edge where both Valid were high.
  - It then points to the requester that lost.
  - Single-requester cycles leave it unchanged.
- Output stage, one-cycle latency:
  - At the transfer edge, WriteRegister and WriteData load the winner's Addr and Data.
  - RegWrite loads 1 unless the winner's Addr==0. A write to register 0 is accepted and dropped, with RegWrite=0.
  - With no transfer, RegWrite loads 0 and WriteRegister/WriteData hold their values.
  - The register file commits the write at the edge that ends the cycle in which RegWrite=1.
- Scoreboard, pending[31:0]:
  - pending[0] is always 0.
  - Set at an edge where ReserveEn=1 and ReserveAddr!=0.
  - Cleared at an edge where RegWrite=1 (the output register), for index WriteRegister.
  - Reserve and clear of the same index at the same edge: reserve wins, bit stays 1. This covers back-to-back producers.
  - Reserve of an index already pending: stays 1. No counting.
- Busy outputs (combinational): Busy1=pending[CheckAddr1], Busy2=pending[CheckAddr2]. No forwarding.
  - A register becomes non-busy in the cycle after its commit edge, when the register file already holds the new value.
- Scoreboard and writeback are independent. An unreserved write still commits normally and clears nothing extra.

Test Plan:
- Reset and idle: assert nReset=0 mid-cycle -> RegWrite, WriteRegister, WriteData and Busy1/2 all 0 immediately. Release with no Valid -> RegWrite stays 0.
- Single writer: ValidA=1, AddrA=5, DataA=0xDEADBEEF for one cycle -> ReadyA=1 that cycle. Next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF. Cycle after that, RegWrite=0.
- Conflict fairness: ValidA and ValidB held high for 4 cycles with distinct Addr/Data -> grants go A, B, A, B. Outputs follow one cycle later in the same order. Ready is never high on both at once.
- Register zero: ValidB=1, AddrB=0, DataB=0x12345678 -> ReadyB=1, and RegWrite stays 0 on the following cycle.
- Scoreboard lifecycle: ReserveEn with ReserveAddr=7, CheckAddr1=7 -> Busy1=1 next cycle. Then A writes reg 7 -> Busy1 stays 1 through the RegWrite cycle and drops to 0 the cycle after. A reserve of 0 never sets Busy.
- Simultaneous reserve and clear: RegWrite=1 with WriteRegister=9 on the same edge as ReserveEn=1, ReserveAddr=9 -> Busy for reg 9 remains 1 afterwards.
